button_conditioner: RTL and testbench

- Conditions a raw, bouncing, asynchronous push-button input into a clean, synchronous level plus single-cycle event pulses.
- Sits directly upstream of the LED/blink logic on the board. Its `btn_level` drives the `rst` input of downstream counters and blinkers, and its pulses drive mode toggles.
- Also flags a long press (hold) for "hold to clear" style controls.

---
 rtl/button_pkg.sv | 14 +
 rtl/button_conditioner_sync.sv | 30 +++
 rtl/button_conditioner.sv | 124 ++++++++++++
 tb/tb_button_conditioner.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and state encoding for the push-button conditioner.
package button_pkg;

  localparam int unsigned DEBOUNCE_20MS_50MHZ = 1000000;
  localparam int unsigned HOLD_1S_50MHZ       = 50000000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_conditioner_sync.sv
// Multi-flop synchroniser for an asynchronous pad input; reset loads RESET_VAL
// so the chain starts at the pad's idle level.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw push-button into a clean level, press/release pulses and a
// long-press hold indication.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter int unsigned HOLD_CYCLES     = HOLD_1S_50MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold,
  output logic hold_pulse
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic sync_out;
  logic s_c;

  btn_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              hold_q, hold_d;
  logic              hold_pulse_q, hold_pulse_d;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_out)
  );

  // s_c = 1 means pressed, whatever the pad polarity
  assign s_c = sync_out ^ ACTIVE_LOW;

  always_comb begin
    state_d  = state_q;
    db_cnt_d = '0;
    level_d  = level_q;

    case (state_q)
      RELEASED, PRESS_WAIT: begin
        if (!s_c) begin
          state_d = RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
        end else begin
          state_d  = PRESS_WAIT;
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      PRESSED, RELEASE_WAIT: begin
        if (s_c) begin
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
        end else begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase

    // Hold counts only across cycles where the press persists, so an accepted
    // release on the would-be hold edge suppresses hold entirely.
    if (level_q && level_d) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end else begin
      hold_cnt_d = '0;
    end

    hold_d       = level_d && (hold_cnt_d == HOLD_MAX);
    press_d      = level_d && !level_q;
    release_d    = !level_d && level_q;
    hold_pulse_d = hold_d && !hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RELEASED;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      hold_q       <= 1'b0;
      hold_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      hold_q       <= hold_d;
      hold_pulse_q <= hold_pulse_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold          = hold_q;
  assign hold_pulse    = hold_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued at
// stimulus time and matched against pulses observed after each clock edge.
module tb_button_conditioner;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned LAT  = SYNC + DB;

  typedef struct {
    int unsigned cyc;
    byte         kind;
  } ev_t;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic btn_in   = 1'b1;
  logic btn_in_h = 1'b0;

  logic btn_level, press_pulse, release_pulse, hold, hold_pulse;
  logic btn_level_h, press_pulse_h, release_pulse_h, hold_h, hold_pulse_h;

  int unsigned cyc    = 0;
  int unsigned lvl_hi = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];

  button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .hold(hold), .hold_pulse(hold_pulse)
  );

  button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .btn_in(btn_in_h), .btn_level(btn_level_h),
    .press_pulse(press_pulse_h), .release_pulse(release_pulse_h),
    .hold(hold_h), .hold_pulse(hold_pulse_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int unsigned c, input byte k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  // Advance n edges, sampling 1 time unit after each; record pulses seen.
  task automatic run(input int n);
    ev_t o;
    repeat (n) begin
      @(posedge clk);
      #1;
      o.cyc = cyc;
      if (press_pulse && release_pulse) begin o.kind = "B"; obs_q.push_back(o); end
      else if (press_pulse)             begin o.kind = "P"; obs_q.push_back(o); end
      else if (release_pulse)           begin o.kind = "R"; obs_q.push_back(o); end
      if (hold_pulse) begin o.kind = "H"; obs_q.push_back(o); end
      if (btn_level) lvl_hi++;
    end
  endtask

  task automatic test_reset();
    ev_t e, o;
    run(3);
    checks++;
    if ({btn_level, press_pulse, release_pulse, hold, hold_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 00000",
               {btn_level, press_pulse, release_pulse, hold, hold_pulse});
    end
    checks++;
    if ({btn_level_h, press_pulse_h, release_pulse_h, hold_h, hold_pulse_h} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs_h: got %b expected 00000",
               {btn_level_h, press_pulse_h, release_pulse_h, hold_h, hold_pulse_h});
    end
    checks++;
    if (dut.u_sync.q !== 1'b1 || dut_h.u_sync.q !== 1'b0) begin
      errors++;
      $display("FAIL reset_sync: got low=%b high=%b expected 1 0", dut.u_sync.q, dut_h.u_sync.q);
    end
    rst = 1'b0;
    run(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL reset_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL reset_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_clean_press();
    ev_t e, o;
    int unsigned c, c2;
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    run(LAT - 1);
    checks++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL clean_early: btn_level got %b expected 0", btn_level); end
    run(1);
    checks++;
    if (btn_level !== 1'b1 || press_pulse !== 1'b1) begin
      errors++; $display("FAIL clean_edge: level/press got %b%b expected 11", btn_level, press_pulse);
    end
    run(1);
    checks++;
    if (press_pulse !== 1'b0) begin errors++; $display("FAIL clean_pulse_width: press got %b expected 0", press_pulse); end
    c2 = cyc;
    btn_in = 1'b1;
    push_exp(c2 + LAT, "R");
    run(LAT + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL clean_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL clean_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL clean_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_bounce();
    ev_t e, o;
    int unsigned c;
    lvl_hi = 0;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      run(2);
    end
    checks++;
    if (lvl_hi != 0) begin errors++; $display("FAIL bounce_level: high for %0d cycles expected 0", lvl_hi); end
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    run(LAT + 2);
    c = cyc;
    btn_in = 1'b1;
    push_exp(c + LAT, "R");
    run(LAT + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL bounce_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL bounce_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bounce_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_glitch();
    ev_t e, o;
    int unsigned c;
    lvl_hi = 0;
    btn_in = 1'b0;
    run(DB - 1);
    btn_in = 1'b1;
    run(LAT + 6);
    checks++;
    if (lvl_hi != 0) begin errors++; $display("FAIL glitch_level: high for %0d cycles expected 0", lvl_hi); end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL glitch_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
    // Shortest accepted press: exactly DB low samples
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    push_exp(c + LAT + DB, "R");
    run(DB);
    btn_in = 1'b1;
    run(LAT + 6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL minpress_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL minpress_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL minpress_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_hold();
    ev_t e, o;
    int unsigned c;
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    push_exp(c + LAT + HOLD, "H");
    run(LAT + HOLD - 1);
    checks++;
    if (hold !== 1'b0) begin errors++; $display("FAIL hold_early: hold got %b expected 0", hold); end
    run(1);
    checks++;
    if (hold !== 1'b1 || hold_pulse !== 1'b1) begin
      errors++; $display("FAIL hold_edge: hold/pulse got %b%b expected 11", hold, hold_pulse);
    end
    run(1);
    checks++;
    if (hold !== 1'b1 || hold_pulse !== 1'b0) begin
      errors++; $display("FAIL hold_after: hold/pulse got %b%b expected 10", hold, hold_pulse);
    end
    run(30 - (LAT + HOLD + 1));
    btn_in = 1'b1;
    push_exp(c + 30 + LAT, "R");
    run(LAT - 1);
    checks++;
    if (hold !== 1'b1 || btn_level !== 1'b1) begin
      errors++; $display("FAIL hold_kept: hold/level got %b%b expected 11", hold, btn_level);
    end
    run(1);
    checks++;
    if (hold !== 1'b0 || btn_level !== 1'b0) begin
      errors++; $display("FAIL hold_drop: hold/level got %b%b expected 00", hold, btn_level);
    end
    run(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL hold_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL hold_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL hold_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_release_vs_hold();
    ev_t e, o;
    int unsigned c;
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    run(HOLD);
    btn_in = 1'b1;
    push_exp(c + HOLD + LAT, "R");
    run(LAT);
    checks++;
    if (hold !== 1'b0 || hold_pulse !== 1'b0 || btn_level !== 1'b0) begin
      errors++; $display("FAIL race_edge: hold/pulse/level got %b%b%b expected 000", hold, hold_pulse, btn_level);
    end
    run(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL race_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL race_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL race_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_async_reset();
    ev_t e, o;
    int unsigned c;
    c = cyc;
    btn_in = 1'b0;
    push_exp(c + LAT, "P");
    push_exp(c + LAT + HOLD, "H");
    run(LAT + HOLD + 4);
    checks++;
    if (hold !== 1'b1 || btn_level !== 1'b1) begin
      errors++; $display("FAIL areset_pre: hold/level got %b%b expected 11", hold, btn_level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({btn_level, press_pulse, release_pulse, hold, hold_pulse} !== 5'b0) begin
      errors++; $display("FAIL areset_outs: got %b expected 00000",
                         {btn_level, press_pulse, release_pulse, hold, hold_pulse});
    end
    run(2);
    rst = 1'b0;
    c = cyc;
    push_exp(c + LAT, "P");
    run(LAT + 2);
    btn_in = 1'b1;
    push_exp(c + LAT + 2 + LAT, "R");
    run(LAT + 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL areset_evt: missing %c@%0d", e.kind, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind) begin
          errors++; $display("FAIL areset_evt: got %c@%0d expected %c@%0d", o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL areset_extra: %0d events, first %c@%0d", obs_q.size(), obs_q[0].kind, obs_q[0].cyc);
      obs_q.delete();
    end
  endtask

  task automatic test_active_high();
    btn_in_h = 1'b1;
    run(LAT - 1);
    checks++;
    if (btn_level_h !== 1'b0) begin errors++; $display("FAIL ah_early: level got %b expected 0", btn_level_h); end
    run(1);
    checks++;
    if (btn_level_h !== 1'b1 || press_pulse_h !== 1'b1) begin
      errors++; $display("FAIL ah_press: level/press got %b%b expected 11", btn_level_h, press_pulse_h);
    end
    btn_in_h = 1'b0;
    run(LAT - 1);
    checks++;
    if (btn_level_h !== 1'b1) begin errors++; $display("FAIL ah_held: level got %b expected 1", btn_level_h); end
    run(1);
    checks++;
    if (btn_level_h !== 1'b0 || release_pulse_h !== 1'b1) begin
      errors++; $display("FAIL ah_release: level/release got %b%b expected 01", btn_level_h, release_pulse_h);
    end
    run(4);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL ah_extra: %0d events on low-active unit", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_hold();
    test_release_vs_hold();
    test_async_reset();
    test_active_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
